// File: rtl/div_unit_if.sv
// Handshake and data bundle between the pipeline and the iterative divider.
// The pipeline side drives the request and operands and watches busy/done;
// the divider side drives status and results.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;

    modport master (
        output start, sign, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, sign, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU. It produces one quotient bit per
// clock on operand magnitudes, then applies the sign correction on the way
// out. Quotient feeds LO and remainder feeds HI. The pipeline stalls while
// busy is high.
//
// Timing: an accepted start enters CALC. CALC runs WIDTH iterations and then
// spends one more cycle applying the sign correction while moving to DONE,
// so done is seen WIDTH+2 cycles after the accept edge. A zero divisor loads
// the iteration counter already at its terminal value, so CALC lasts a single
// cycle and no iterations run.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    count;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             zero_q;

    logic             dvd_in_neg;
    logic             dvs_in_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] rem_dz;

    // Operand conditioning: magnitudes are taken only for signed division.
    always_comb begin
        dvd_in_neg = bus.sign & bus.dividend[WIDTH-1];
        dvs_in_neg = bus.sign & bus.divisor[WIDTH-1];
        dvd_abs    = dvd_in_neg ? -bus.dividend : bus.dividend;
        dvs_abs    = dvs_in_neg ? -bus.divisor : bus.divisor;
    end

    // One restoring step: shift {rem,quo} left and try subtracting the divisor.
    // The partial remainder is always below the divisor, so bit WIDTH of the
    // trial difference is exactly the borrow.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        rem_next = shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction of the magnitude results. The overflow case
    // (most negative / -1) falls out naturally as a truncated negation.
    // For a zero divisor quo_q still holds the untouched dividend magnitude,
    // which is turned back into the original dividend for the remainder.
    always_comb begin
        quo_fix = (dvd_neg ^ dvs_neg) ? -quo_q : quo_q;
        rem_fix = dvd_neg ? -rem_q : rem_q;
        rem_dz  = dvd_neg ? -quo_q : quo_q;
    end

    // Control FSM with registered busy/done and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            count         <= '0;
            dvd_neg       <= 1'b0;
            dvs_neg       <= 1'b0;
            zero_q        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        dvd_neg  <= dvd_in_neg;
                        dvs_neg  <= dvs_in_neg;
                        quo_q    <= dvd_abs;
                        dvs_q    <= dvs_abs;
                        rem_q    <= '0;
                        bus.dbz  <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                        if (bus.divisor == '0) begin
                            zero_q <= 1'b1;
                            count  <= CW'(WIDTH);
                        end else begin
                            zero_q <= 1'b0;
                            count  <= '0;
                        end
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                CALC: begin
                    if (count == CW'(WIDTH)) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                        if (zero_q) begin
                            bus.quotient  <= '1;
                            bus.remainder <= rem_dz;
                            bus.dbz       <= 1'b1;
                        end else begin
                            bus.quotient  <= quo_fix;
                            bus.remainder <= rem_fix;
                            bus.dbz       <= 1'b0;
                        end
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed and randomised checks for div_unit: a table of hand-computed
// divisions, hand-written multi-cycle corner sequences, and random operands
// compared against the language's own / and % operators.
module tb_div_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        sign;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges somewhere unexpected.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: present a request for one cycle, then scramble the
    // operands so that only the accept-cycle values can matter.
    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.sign     = s;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        bus.sign     = ~s;
    endtask

    // Latency in cycles counted from the accept edge (that edge is 1);
    // returns 101 when done never shows up.
    task automatic waitDone(output int lat);
        lat = 1;
        while (lat <= 100) begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int lat;
        applyStimulus(v.sign, v.dvd, v.dvs);
        waitDone(lat);
        checkOutput({tag, " latency"}, 32'(lat), v.dz ? 32'd2 : 32'd34);
        checkOutput({tag, " quotient"}, bus.quotient, v.q);
        checkOutput({tag, " remainder"}, bus.remainder, v.r);
        checkOutput({tag, " dbz"}, {31'd0, bus.dbz}, {31'd0, v.dz});
        @(negedge clk);
        checkOutput({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int   lat;
        int   pulses;
        vec_t rv;
        logic signed [31:0] sa;
        logic signed [31:0] sb;

        errors = 0;
        checks = 0;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
        vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
        vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
        vecs[4]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
        vecs[5]  = '{1'b0, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      1'b1};
        vecs[6]  = '{1'b1, 32'hFFFFFF00,  32'd0,         32'hFFFFFFFF,  32'hFFFFFF00,  1'b1};
        vecs[7]  = '{1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
        vecs[8]  = '{1'b1, 32'd12345,     32'd1,         32'd12345,     32'd0,         1'b0};
        vecs[9]  = '{1'b1, 32'd12345,     32'hFFFFFFFF,  32'hFFFFCFC7,  32'd0,         1'b0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  32'hF,         1'b0};
        vecs[11] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
        vecs[12] = '{1'b0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  32'd1,         1'b0};
        vecs[13] = '{1'b1, 32'd0,         32'hFFFFFFF9,  32'd0,         32'd0,         1'b0};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset quotient", bus.quotient, 32'd0);
        checkOutput("reset remainder", bus.remainder, 32'd0);
        checkOutput("reset dbz", {31'd0, bus.dbz}, 32'd0);

        $display("[TB] directed table");
        for (int i = 0; i < 14; i++)
            runVector(vecs[i], $sformatf("vec%0d", i));

        $display("[TB] start while busy, then start in the done cycle");
        applyStimulus(1'b0, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        bus.start    = 1'b1;
        bus.sign     = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(lat);
        checkOutput("ignored start latency", 32'(lat), 32'd26);
        checkOutput("ignored start quotient", bus.quotient, 32'd14);
        checkOutput("ignored start remainder", bus.remainder, 32'd2);
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2);
        #3;
        checkOutput("back-to-back busy", {31'd0, bus.busy}, 32'd1);
        checkOutput("back-to-back done low", {31'd0, bus.done}, 32'd0);
        checkOutput("back-to-back quotient held", bus.quotient, 32'd14);
        waitDone(lat);
        checkOutput("back-to-back latency", 32'(lat), 32'd34);
        checkOutput("back-to-back quotient", bus.quotient, 32'hFFFFFFFD);
        checkOutput("back-to-back remainder", bus.remainder, 32'hFFFFFFFF);
        @(negedge clk);

        $display("[TB] dbz clears on the next accepted start");
        runVector(vecs[5], "dz again");
        applyStimulus(1'b0, 32'd100, 32'd7);
        #3;
        checkOutput("dbz cleared", {31'd0, bus.dbz}, 32'd0);
        checkOutput("quotient held over start", bus.quotient, 32'hFFFFFFFF);
        checkOutput("remainder held over start", bus.remainder, 32'h1234);
        waitDone(lat);
        checkOutput("after dz latency", 32'(lat), 32'd34);
        checkOutput("after dz quotient", bus.quotient, 32'd14);
        @(negedge clk);

        $display("[TB] reset in the middle of an iteration");
        applyStimulus(1'b0, 32'd1000, 32'd3);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort done", {31'd0, bus.done}, 32'd0);
        checkOutput("abort quotient", bus.quotient, 32'd0);
        checkOutput("abort remainder", bus.remainder, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        checkOutput("abort no done pulse", 32'(pulses), 32'd0);
        runVector(vecs[0], "after abort");

        $display("[TB] random operands");
        for (int i = 0; i < 300; i++) begin
            rv.sign = 1'($urandom_range(0, 1));
            rv.dvd  = $urandom;
            case ($urandom_range(0, 5))
                0:       rv.dvs = 32'd1;
                1:       rv.dvs = 32'hFFFFFFFF;
                2:       rv.dvs = 32'($urandom_range(1, 20));
                default: rv.dvs = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) rv.dvd = 32'd0;
            if (rv.dvs == 32'd0) rv.dvs = 32'd1;
            if (rv.sign && rv.dvd == 32'h80000000 && rv.dvs == 32'hFFFFFFFF) rv.dvs = 32'd3;
            rv.dz = 1'b0;
            if (rv.sign) begin
                sa   = rv.dvd;
                sb   = rv.dvs;
                rv.q = sa / sb;
                rv.r = sa % sb;
            end else begin
                rv.q = rv.dvd / rv.dvs;
                rv.r = rv.dvd % rv.dvs;
            end
            runVector(rv, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
